// File: rtl/proc_pkg.sv
// Shared types and constants for the request encoder and its round-robin arbiter.
package proc_pkg;

  localparam int N_REQ  = 13;
  localparam int CODE_W = 4;

  typedef logic [N_REQ-1:0]  req_vec_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_VALID = 1'b1
  } enc_state_t;

  // Pointer value that makes the first search begin at line 0.
  localparam code_t PTR_RESET = 4'd12;

  function automatic req_vec_t code_onehot(input code_t code);
    req_vec_t vec;
    vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      vec[i] = (code == code_t'(i));
    end
    return vec;
  endfunction

endpackage

// File: rtl/req_encoder_rr_arbiter.sv
// Combinational round-robin search: first eligible line at or after ptr+1, wrapping 12 -> 0.
module rr_arbiter
  import proc_pkg::*;
(
  input  req_vec_t elig,
  input  code_t    ptr,
  output logic     found,
  output code_t    win_idx
);

  logic [2*N_REQ-1:0] dbl_s;
  req_vec_t           rot_s;
  code_t              start_s;
  code_t              off_s;
  logic [CODE_W:0]    sum_s;

  // Rotate the doubled vector so the search start sits at bit 0, then take the lowest set bit.
  always_comb begin
    if (ptr >= code_t'(N_REQ - 1)) begin
      start_s = 4'd0;
    end else begin
      start_s = ptr + 4'd1;
    end
    dbl_s = {elig, elig};
    rot_s = req_vec_t'(dbl_s >> start_s);
    found = 1'b0;
    off_s = 4'd0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        found = 1'b1;
        off_s = code_t'(j);
      end else begin
        found = found;
      end
    end
    sum_s = {1'b0, start_s} + {1'b0, off_s};
    if (sum_s >= 5'(N_REQ)) begin
      win_idx = code_t'(sum_s - 5'(N_REQ));
    end else begin
      win_idx = code_t'(sum_s);
    end
  end

endmodule

// File: rtl/req_encoder.sv
// Registered 13-to-4 request encoder: sticky pending register, round-robin grant,
// and a valid/ack output handshake delivering at most one code per cycle.
module req_encoder
  import proc_pkg::*;
#(
  parameter int N_REQ  = proc_pkg::N_REQ,
  parameter int CODE_W = proc_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_in,
  input  logic [N_REQ-1:0]  mask,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ack,
  output logic [N_REQ-1:0]  pending_out
);

  enc_state_t state_r, state_next_s;
  req_vec_t   pend_r, pend_next_s;
  code_t      code_r, ptr_r;

  logic     ack_s, load_s, found_s;
  req_vec_t code_hot_s, clr_s, held_s, elig_s;
  code_t    win_s;

  // Pending update and eligibility; the held or acked code never competes again this cycle.
  always_comb begin
    ack_s      = (state_r == ENC_VALID) && code_ack;
    code_hot_s = code_onehot(code_r);
    if (ack_s) begin
      clr_s  = code_hot_s;
      held_s = '0;
    end else if (state_r == ENC_VALID) begin
      clr_s  = '0;
      held_s = code_hot_s;
    end else begin
      clr_s  = '0;
      held_s = '0;
    end
    elig_s      = pend_r & ~mask & ~held_s & ~clr_s;
    pend_next_s = (pend_r & ~clr_s) | req_in;
  end

  rr_arbiter u_arb (
    .elig    (elig_s),
    .ptr     (ptr_r),
    .found   (found_s),
    .win_idx (win_s)
  );

  // Output FSM: load a winner from IDLE, or back-to-back on an ack in VALID.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ENC_IDLE: begin
        if (found_s) begin
          load_s       = 1'b1;
          state_next_s = ENC_VALID;
        end else begin
          state_next_s = ENC_IDLE;
        end
      end
      ENC_VALID: begin
        if (ack_s && found_s) begin
          load_s       = 1'b1;
          state_next_s = ENC_VALID;
        end else if (ack_s) begin
          state_next_s = ENC_IDLE;
        end else begin
          state_next_s = ENC_VALID;
        end
      end
      default: begin
        state_next_s = ENC_IDLE;
      end
    endcase
  end

  // State, pending, output code and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ENC_IDLE;
      pend_r  <= '0;
      code_r  <= 4'd0;
      ptr_r   <= PTR_RESET;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
      if (load_s) begin
        code_r <= win_s;
        ptr_r  <= win_s;
      end else begin
        code_r <= code_r;
        ptr_r  <= ptr_r;
      end
    end
  end

  assign code_out    = code_r;
  assign code_valid  = (state_r == ENC_VALID);
  assign pending_out = pend_r;

endmodule

// File: tb/tb_req_encoder.sv
// Directed plus randomized bench for req_encoder against a behavioural grant model.
module tb_req_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] req_in;
  logic [12:0] mask;
  logic        code_ack;
  logic [3:0]  code_out;
  logic        code_valid;
  logic [12:0] pending_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit m_valid;
  int m_code;
  int m_ptr;
  bit m_pend[13];

  req_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .mask        (mask),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .code_ack    (code_ack),
    .pending_out (pending_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pend_word();
    int w;
    w = 0;
    for (int i = 0; i < 13; i++) if (m_pend[i]) w += (1 << i);
    return w;
  endfunction

  task automatic drive(input int r, input int m, input bit a, input bit rs);
    req_in   = 13'(r);
    mask     = 13'(m);
    code_ack = a;
    rst      = rs;
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic tick();
    bit nv;
    int nc, np_tr, w;
    bit found, ack;
    bit np[13];
    nv = m_valid; nc = m_code; np_tr = m_ptr;
    if (rst) begin
      nv = 0; nc = 0; np_tr = 12;
      for (int i = 0; i < 13; i++) np[i] = 0;
    end else begin
      ack = m_valid && code_ack;
      found = 0; w = 0;
      for (int k = 1; k <= 13; k++) begin
        int idx;
        idx = (m_ptr + k) % 13;
        if (!found && m_pend[idx] && !mask[idx] && !(m_valid && idx == m_code)) begin
          found = 1; w = idx;
        end
      end
      for (int i = 0; i < 13; i++)
        np[i] = (m_pend[i] && !(ack && i == m_code)) || req_in[i];
      if (!m_valid || ack) begin
        if (found) begin nv = 1; nc = w; np_tr = w; end
        else nv = 0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_code = nc; m_ptr = np_tr;
    for (int i = 0; i < 13; i++) m_pend[i] = np[i];
    check("model_valid", int'(code_valid), int'(m_valid));
    check("model_pending", int'(pending_out), pend_word());
    if (m_valid) check("model_code", int'(code_out), m_code);
  endtask

  initial begin
    m_valid = 0; m_code = 0; m_ptr = 12;
    for (int i = 0; i < 13; i++) m_pend[i] = 0;
    drive(0, 0, 0, 1);
    @(negedge clk);

    // Reset with every request line high.
    drive(13'h1FFF, 0, 0, 1);
    tick(); tick();
    check("rst_valid", int'(code_valid), 0);
    check("rst_pending", int'(pending_out), 0);
    check("rst_code", int'(code_out), 0);

    // Single request on line 5.
    drive(1 << 5, 0, 1, 0); tick();
    check("single_pend", int'(pending_out), 32'h20);
    check("single_early", int'(code_valid), 0);
    drive(0, 0, 1, 0); tick();
    check("single_valid", int'(code_valid), 1);
    check("single_code", int'(code_out), 5);
    tick();
    check("single_drop", int'(code_valid), 0);
    check("single_clear", int'(pending_out), 0);

    // Round-robin from a fresh pointer, then wrap-around.
    drive(0, 0, 0, 1); tick();
    drive(13'h1009, 0, 1, 0); tick();
    drive(0, 0, 1, 0); tick();
    check("rr_first", int'(code_out), 0);
    tick(); check("rr_second", int'(code_out), 3);
    tick(); check("rr_third", int'(code_out), 12);
    check("rr_third_v", int'(code_valid), 1);
    tick(); check("rr_done", int'(code_valid), 0);
    drive(13'h1001, 0, 1, 0); tick();
    drive(0, 0, 1, 0); tick();
    check("wrap_first", int'(code_out), 0);
    tick(); check("wrap_second", int'(code_out), 12);
    tick(); check("wrap_done", int'(code_valid), 0);

    // Stall with code 7, then re-request on the ack cycle.
    drive(1 << 7, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_code", int'(code_out), 7);
      check("stall_valid", int'(code_valid), 1);
    end
    drive(1 << 7, 0, 1, 0); tick();
    check("rereq_pend", int'(pending_out), 32'h80);
    drive(0, 0, 0, 0); tick();
    check("rereq_again", int'(code_out), 7);
    check("rereq_again_v", int'(code_valid), 1);
    drive(0, 0, 1, 0); tick();
    check("rereq_clear", int'(pending_out), 0);

    // Masked line stays pending and is never granted until unmasked.
    drive(1 << 2, 1 << 2, 1, 0); tick();
    drive(0, 1 << 2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mask_novalid", int'(code_valid), 0);
      check("mask_pend", int'(pending_out), 4);
    end
    drive(0, 0, 0, 0); tick();
    check("unmask_code", int'(code_out), 2);
    check("unmask_valid", int'(code_valid), 1);
    drive(0, 0, 1, 0); tick();

    // Reset in the middle of a handshake with code 9 held and line 4 pending.
    drive(13'h210, 13'h010, 0, 0); tick();
    drive(0, 13'h010, 0, 0); tick();
    check("mid_code", int'(code_out), 9);
    drive(0, 0, 0, 0); tick();
    check("mid_hold", int'(code_out), 9);
    check("mid_pend", int'(pending_out), 32'h210);
    drive(0, 0, 0, 1); tick();
    check("mid_rst_valid", int'(code_valid), 0);
    check("mid_rst_pend", int'(pending_out), 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale", int'(code_valid), 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r, m;
      r = int'($urandom & $urandom & $urandom) & 32'h1FFF;
      m = ($urandom_range(0, 3) == 0) ? (int'($urandom & $urandom) & 32'h1FFF) : 0;
      drive(r, m, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
# req_encoder

Registered 13-to-4 request encoder with round-robin arbitration and a valid/ack output handshake. It collects one-hot-style request lines from processor units into a sticky pending register and emits one 4-bit index code at a time. Code `i` corresponds to request line `i`, so feeding `code_out` into the existing 4-to-13 decoder reproduces the granted line. It sits between the request sources and the control unit that consumes encoded service codes.

## Interface
- `N_REQ`, default 13: number of request lines. Fixed at 13 for this design.
- `CODE_W`, default 4: width of the output code.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_in`  in  13  request lines, sampled every cycle. Any number may be high at once.
- `mask`  in  13  1 = line is ineligible for grant. The line still latches into pending.
- `code_out`  out  4  encoded index of the granted line, 0..12. Values 13..15 are never produced.
- `code_valid`  out  1  `code_out` holds a granted request.
- `code_ack`  in  1  consumer accepts `code_out`. Only meaningful while `code_valid` = 1.
- `pending_out`  out  13  current pending register, for debug and status.

## Operation
- **Pending register:** `pend_next = (pend & ~clr) | req_in`.
  - `clr` is one-hot of the code being acknowledged this cycle, otherwise 0.
  - If `req_in[i]` is high in the same cycle bit `i` is acked, the bit stays pending.
- **Eligibility:** `elig = pend & ~mask & ~held`.
  - `held` is one-hot of `code_out` while `code_valid` = 1 and there is no ack this cycle.
  - On an ack cycle, `held` = 0 and the acked bit is excluded through `clr`.
- **Round-robin search:** starts at `ptr+1` and wraps 12→0. The first eligible index wins.
  - `ptr` updates to the winning index when that winner is loaded into the output register.
- **Output FSM, two states:**
  - `IDLE` (`code_valid` = 0):
    - If `elig` ≠ 0, load the winner into `code_out` and go to `VALID`.
  - `VALID` (`code_valid` = 1):
    - `code_ack` = 0: hold `code_out` stable.
    - `code_ack` = 1 and next winner exists: load it and stay in `VALID` (back-to-back).
    - `code_ack` = 1 and no winner: go to `IDLE`.
- **Arbitration input:** the winner is computed from registered `pend` and current `mask`, never from raw `req_in`.
- **Mask changes:** a mask change while in `VALID` does not retract the held code.
- **Ack while `IDLE`:** ignored. Pending is unchanged.
- **Reset values:**
  - `pend` = 0, `pending_out` = 0
  - `code_out` = 0, `code_valid` = 0, state = `IDLE`
  - `ptr` = 12, so the first search starts at index 0.

## Timing
- `req_in[i]` high in cycle t → `pending_out[i]` = 1 in t+1 → `code_valid` = 1 with `code_out` = i in t+2, if it wins.
- `code_ack` in cycle t:
  - Acked bit cleared from `pending_out` in t+1.
  - Next code, if any, valid in t+1. Throughput is one code per cycle.
- `rst` in cycle t: all outputs at reset values in t+1, even in mid-handshake. Requests sampled in cycle t are discarded.
- All eligible bits masked: `code_valid` stays 0. Pending bits persist indefinitely.
- Fairness: a continuously eligible line is granted within 13 grants.

## Structure
- **Shared package** `proc_pkg`:
  - `N_REQ` = 13, `CODE_W` = 4.
  - Typedefs `req_vec_t` (13 bits) and `code_t` (4 bits).
  - State enum `ENC_IDLE` / `ENC_VALID`.
- **Sub-module** `rr_arbiter`, combinational:
  - Inputs: `elig`, `ptr`.
  - Outputs: `found`, `win_idx`.
  - Implemented as a double-width rotate plus priority search.
- **Top level** `req_encoder`: pending register, output register, FSM and pointer.

## Test plan
- **Reset:** assert `rst` 2 cycles with `req_in` = 13'h1FFF → `code_valid` = 0, `pending_out` = 0, `code_out` = 0.
- **Single request:** pulse `req_in[5]` 1 cycle, `code_ack` held 1 → `code_out` = 5 and `code_valid` = 1 exactly two cycles after the pulse, for one cycle. `pending_out` = 0 afterwards.
- **Round-robin:**
  - Stimulus: `req_in` = bits {0, 3, 12} pulsed once, `code_ack` = 1.
  - Required: codes 0, 3, 12 on consecutive cycles.
  - Then re-pulse {0, 12} with `ptr` = 12 → order 0, 12. Confirms wrap-around.
- **Stall, re-request and mask:**
  - Hold `code_ack` = 0 with code 7 valid for 5 cycles → `code_out` stable at 7.
  - Assert `req_in[7]` on the ack cycle → `pending_out[7]` stays 1 and code 7 reappears later.
  - Mask bit 2 while pending → 2 never granted. Unmask → 2 granted.
- **Reset mid-handshake:** `code_valid` = 1 with code 9, pending {4, 9}; assert `rst` → next cycle `code_valid` = 0, `pending_out` = 0. After release, code 4 is not produced unless re-requested.
